// File: rtl/noc_flit_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : noc_flit_pkg                                                 |
// | Description : Shared flit layout, flit types and width helpers for the     |
// |               tile splitter, egress queue and packet collector.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package noc_flit_pkg;

    localparam int c_ftypeW = 2;
    localparam int c_instrW = 3;
    localparam int c_dataW  = 16;
    localparam int c_ftypeLsb = 0;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } ftype_e;

    function automatic int addrWidth(input int nodeCount);
        return $clog2(nodeCount);
    endfunction

    // Layout MSB->LSB: valid | dest | src | data | instr | packet_id | ftype
    function automatic int flitWidth(input int nodeCount, input int pidWidth);
        return 1 + 2 * addrWidth(nodeCount) + c_dataW + c_instrW + pidWidth + c_ftypeW;
    endfunction

endpackage

`default_nettype wire

// File: rtl/flit_sync_fifo.sv
// +----------------------------------------------------------------------------+
// | Module      : flit_sync_fifo                                               |
// | Description : Single-clock flit FIFO; head is presented from registered    |
// |               state and reads as all-zero when empty.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module flit_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_pushData,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_headData,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_occupancy
);

    localparam int c_ptrW = $clog2(DEPTH);
    localparam int c_occW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_occW-1:0] r_occ;

    logic w_full;
    logic w_empty;
    logic w_doPush;
    logic w_doPop;

    assign w_full   = (r_occ == c_occW'(DEPTH));
    assign w_empty  = (r_occ == '0);
    assign w_doPush = i_push & ~w_full;
    assign w_doPop  = i_pop & ~w_empty;

    // Storage carries no reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_occ   <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_ptrW'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + c_ptrW'(1);
            end
            unique case ({w_doPush, w_doPop})
                2'b10:   r_occ <= r_occ + c_occW'(1);
                2'b01:   r_occ <= r_occ - c_occW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_headData  = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_occupancy = r_occ;

endmodule

`default_nettype wire

// File: rtl/tile_flit_egress_queue.sv
// +----------------------------------------------------------------------------+
// | Module      : tile_flit_egress_queue                                       |
// | Description : Buffers tile flits toward the router injection port, checks  |
// |               head/body/tail framing and counts injected flits/packets.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_flit_egress_queue
    import noc_flit_pkg::*;
#(
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int DEPTH           = 4,
    parameter int CNT_W           = 16,
    localparam int FLIT_W         = flitWidth(NODE_COUNT, PACKET_ID_WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] flit_in,
    output logic              tile_ready,
    output logic [FLIT_W-1:0] flit_out,
    input  logic              router_ready,
    output logic [CNT_W-1:0]  flit_count,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              proto_err,
    output logic              drop_err
);

    localparam int c_occW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frameState_e;

    logic              w_full;
    logic              w_empty;
    logic [c_occW-1:0] w_occupancy;
    logic [FLIT_W-1:0] w_head;
    logic              w_inValid;
    logic              w_push;
    logic              w_pop;
    ftype_e            w_inType;
    ftype_e            w_outType;

    frameState_e       r_state;
    logic              r_protoErr;
    logic              r_dropErr;
    logic [CNT_W-1:0]  r_flitCount;
    logic [CNT_W-1:0]  r_pktCount;

    // Ready depends on registered occupancy only, never on router_ready.
    assign tile_ready = (w_occupancy < c_occW'(DEPTH));
    assign w_inValid  = flit_in[FLIT_W-1];
    assign w_push     = w_inValid & tile_ready;
    assign w_pop      = ~w_empty & router_ready;
    assign w_inType   = ftype_e'(flit_in[c_ftypeLsb +: c_ftypeW]);
    assign w_outType  = ftype_e'(w_head[c_ftypeLsb +: c_ftypeW]);

    flit_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pushData  (flit_in),
        .i_pop       (w_pop),
        .o_headData  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_occupancy (w_occupancy)
    );

    // Framing is advisory: errors are flagged but the flit is still stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_protoErr <= 1'b0;
        end else if (w_push) begin
            unique case (w_inType)
                FT_HEAD: begin
                    if (r_state == ST_IN_PKT) r_protoErr <= 1'b1;
                    r_state <= ST_IN_PKT;
                end
                FT_BODY: begin
                    if (r_state == ST_IDLE) r_protoErr <= 1'b1;
                end
                FT_TAIL: begin
                    if (r_state == ST_IDLE) r_protoErr <= 1'b1;
                    r_state <= ST_IDLE;
                end
                FT_SINGLE: begin
                    if (r_state == ST_IN_PKT) r_protoErr <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dropErr   <= 1'b0;
            r_flitCount <= '0;
            r_pktCount  <= '0;
        end else begin
            if (w_inValid && w_full) begin
                r_dropErr <= 1'b1;
            end
            if (w_pop) begin
                r_flitCount <= r_flitCount + CNT_W'(1);
                if (w_outType == FT_TAIL || w_outType == FT_SINGLE) begin
                    r_pktCount <= r_pktCount + CNT_W'(1);
                end
            end
        end
    end

    assign flit_out   = w_head;
    assign flit_count = r_flitCount;
    assign pkt_count  = r_pktCount;
    assign proto_err  = r_protoErr;
    assign drop_err   = r_dropErr;

endmodule

`default_nettype wire

// File: tb/tb_tile_flit_egress_queue.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_tile_flit_egress_queue                                    |
// | Description : Scoreboard bench for the tile egress queue.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tile_flit_egress_queue;

    localparam int c_flitW = 35;
    localparam int c_cntW  = 16;

    localparam logic [1:0] c_head   = 2'b00;
    localparam logic [1:0] c_body   = 2'b01;
    localparam logic [1:0] c_tail   = 2'b10;
    localparam logic [1:0] c_single = 2'b11;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [c_flitW-1:0] flit_in = '0;
    logic               tile_ready;
    logic [c_flitW-1:0] flit_out;
    logic               router_ready = 1'b0;
    logic [c_cntW-1:0]  flit_count;
    logic [c_cntW-1:0]  pkt_count;
    logic               proto_err;
    logic               drop_err;

    int checks = 0;
    int errors = 0;
    logic [c_flitW-1:0] sbq [$];

    always #5 clk = ~clk;

    tile_flit_egress_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in      (flit_in),
        .tile_ready   (tile_ready),
        .flit_out     (flit_out),
        .router_ready (router_ready),
        .flit_count   (flit_count),
        .pkt_count    (pkt_count),
        .proto_err    (proto_err),
        .drop_err     (drop_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [c_flitW-1:0] mk(input logic [1:0] ft, input logic [4:0] pid,
                                              input logic [15:0] d);
        return {1'b1, 4'd1, 4'd2, d, 3'd5, pid, ft};
    endfunction

    task automatic push(input logic [c_flitW-1:0] f, input logic expAcc);
        flit_in = f;
        check("tile_ready", {63'd0, tile_ready}, {63'd0, expAcc});
        if (expAcc) sbq.push_back(f);
        @(posedge clk);
        #1;
        flit_in = '0;
    endtask

    task automatic checkState(input string tag, input logic [15:0] fc, input logic [15:0] pc,
                              input logic pe, input logic de);
        check({tag, "_flit_count"}, {48'd0, flit_count}, {48'd0, fc});
        check({tag, "_pkt_count"},  {48'd0, pkt_count},  {48'd0, pc});
        check({tag, "_proto_err"},  {63'd0, proto_err},  {63'd0, pe});
        check({tag, "_drop_err"},   {63'd0, drop_err},   {63'd0, de});
    endtask

    // Monitor: every pop must match the oldest expected flit.
    always @(negedge clk) begin
        if (!rst && flit_out[c_flitW-1] && router_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%0h expected=none", flit_out);
            end else begin
                check("flit_out_order", {29'd0, flit_out}, {29'd0, sbq.pop_front()});
            end
        end
    end

    initial begin
        logic [c_flitW-1:0] f;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_tile_ready", {63'd0, tile_ready}, 64'd1);
        check("reset_flit_out", {29'd0, flit_out}, 64'd0);
        checkState("reset", 16'd0, 16'd0, 1'b0, 1'b0);

        // Single flit: no bypass, visible the cycle after the push
        router_ready = 1'b1;
        f = mk(c_single, 5'd3, 16'hBEEF);
        flit_in = f;
        check("no_bypass", {29'd0, flit_out}, 64'd0);
        push(f, 1'b1);
        check("single_latency", {29'd0, flit_out}, {29'd0, f});
        @(posedge clk);
        #1;
        checkState("single", 16'd1, 16'd1, 1'b0, 1'b0);
        check("single_drained", {29'd0, flit_out}, 64'd0);

        // Backpressure: fill, drop a fifth flit, then release
        router_ready = 1'b0;
        push(mk(c_head, 5'd7, 16'h1000), 1'b1);
        push(mk(c_body, 5'd7, 16'h1001), 1'b1);
        push(mk(c_body, 5'd7, 16'h1002), 1'b1);
        push(mk(c_tail, 5'd7, 16'h1003), 1'b1);
        check("hold_head", {29'd0, flit_out}, {29'd0, mk(c_head, 5'd7, 16'h1000)});
        push(mk(c_head, 5'd8, 16'h2000), 1'b0);
        check("drop_err_set", {63'd0, drop_err}, 64'd1);
        router_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkState("release", 16'd5, 16'd2, 1'b0, 1'b1);
        check("release_empty", {29'd0, flit_out}, 64'd0);

        // Full, then sustained push+pop at one flit per cycle
        router_ready = 1'b0;
        push(mk(c_head, 5'd9, 16'h3000), 1'b1);
        push(mk(c_body, 5'd9, 16'h3001), 1'b1);
        push(mk(c_body, 5'd9, 16'h3002), 1'b1);
        push(mk(c_body, 5'd9, 16'h3003), 1'b1);
        router_ready = 1'b1;
        push(mk(c_body, 5'd9, 16'h3004), 1'b0);
        push(mk(c_body, 5'd9, 16'h3004), 1'b1);
        push(mk(c_body, 5'd9, 16'h3005), 1'b1);
        push(mk(c_body, 5'd9, 16'h3006), 1'b1);
        push(mk(c_body, 5'd9, 16'h3007), 1'b1);
        push(mk(c_tail, 5'd9, 16'h3008), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkState("stream", 16'd14, 16'd3, 1'b0, 1'b1);
        check("stream_empty", {29'd0, flit_out}, 64'd0);

        // Framing errors: BODY while idle, then HEAD, HEAD
        push(mk(c_body, 5'd10, 16'h4000), 1'b1);
        check("proto_body_idle", {63'd0, proto_err}, 64'd1);
        push(mk(c_head, 5'd11, 16'h4001), 1'b1);
        push(mk(c_head, 5'd12, 16'h4002), 1'b1);
        @(posedge clk);
        #1;
        checkState("framing", 16'd17, 16'd3, 1'b1, 1'b1);

        // Mid-packet reset discards buffered flits and clears everything
        router_ready = 1'b0;
        push(mk(c_head, 5'd13, 16'h5000), 1'b1);
        push(mk(c_body, 5'd13, 16'h5001), 1'b1);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_flit_out", {29'd0, flit_out}, 64'd0);
        check("midrst_tile_ready", {63'd0, tile_ready}, 64'd1);
        checkState("midrst", 16'd0, 16'd0, 1'b0, 1'b0);
        router_ready = 1'b1;
        push(mk(c_single, 5'd14, 16'h6000), 1'b1);
        @(posedge clk);
        #1;
        checkState("post_rst_single", 16'd1, 16'd1, 1'b0, 1'b0);

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
